// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the PC, the instruction-memory handshake and the
// IF/ID register. Applies jump-controller redirects, absorbs stalls in a
// one-entry skid buffer and drops responses made stale by a redirect.
// Optional statistics counters are enabled by defining FETCH_REDIRECT_STATS_EN.
module fetch_redirect_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [1:0]      m4_1_cnt,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid,
   output logic            id_ex_flush,
   output logic            misalign_err
`ifdef FETCH_REDIRECT_STATS_EN
   ,
   output logic [31:0]     redirect_count,
   output logic [31:0]     discard_count,
   output logic [31:0]     stall_cycles
`endif
);

   typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic            misalign_q, misalign_d;

   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] raw_target;
   logic [XLEN-1:0] target;
   logic            target_misaligned;
   logic            resp_dropped;

   assign pc_plus4 = pc_q + XLEN'(4);

   // Redirect target selection; low bits are forced to word alignment.
   always_comb begin
      unique case (m4_1_cnt)
         2'b01:   raw_target = branch_target;
         2'b10:   raw_target = jump_target;
         default: raw_target = pc_plus4;
      endcase
      target            = {raw_target[XLEN-1:2], 2'b00};
      target_misaligned = (raw_target[1:0] != 2'b00);
   end

   // Next-state logic: flush beats stall beats normal progress in every state.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redirect_pc_d = redirect_pc_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      misalign_d    = misalign_q | (flush & target_misaligned);
      resp_dropped  = 1'b0;

      if (flush) begin
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
      end

      unique case (state_q)
         StFetch: begin
            if (imem_ready) begin
               if (flush) begin
                  resp_dropped = 1'b1;
                  pc_d         = target;
               end else if (!stall) begin
                  if_id_pc_d    = pc_q;
                  if_id_instr_d = imem_rdata;
                  if_id_valid_d = 1'b1;
                  pc_d          = pc_plus4;
               end else begin
                  skid_pc_d    = pc_q;
                  skid_instr_d = imem_rdata;
                  pc_d         = pc_plus4;
                  state_d      = StHold;
               end
            end else if (flush) begin
               // Keep pc so the outstanding address stays stable.
               redirect_pc_d = target;
               state_d       = StDiscard;
            end
         end
         StHold: begin
            if (flush) begin
               pc_d    = target;
               state_d = StFetch;
            end else if (!stall) begin
               if_id_pc_d    = skid_pc_q;
               if_id_instr_d = skid_instr_q;
               if_id_valid_d = 1'b1;
               state_d       = StFetch;
            end
         end
         StDiscard: begin
            if (flush) begin
               redirect_pc_d = target;
            end
            if (imem_ready) begin
               resp_dropped = 1'b1;
               pc_d         = flush ? target : redirect_pc_q;
               state_d      = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StFetch;
         pc_q          <= RESET_PC;
         redirect_pc_q <= '0;
         skid_pc_q     <= '0;
         skid_instr_q  <= '0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redirect_pc_q <= redirect_pc_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem_req     = (state_q != StHold);
   assign imem_addr    = pc_q;
   assign if_id_pc     = if_id_pc_q;
   assign if_id_instr  = if_id_instr_q;
   assign if_id_valid  = if_id_valid_q;
   assign id_ex_flush  = flush;
   assign misalign_err = misalign_q;

`ifdef FETCH_REDIRECT_STATS_EN
   logic [31:0] redirect_count_q, redirect_count_d;
   logic [31:0] discard_count_q, discard_count_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Saturating event counters.
   always_comb begin
      redirect_count_d = redirect_count_q;
      discard_count_d  = discard_count_q;
      stall_cycles_d   = stall_cycles_q;
      if (flush && (redirect_count_q != 32'hFFFF_FFFF)) redirect_count_d = redirect_count_q + 32'd1;
      if (resp_dropped && (discard_count_q != 32'hFFFF_FFFF)) discard_count_d = discard_count_q + 32'd1;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_count_q <= '0;
         discard_count_q  <= '0;
         stall_cycles_q   <= '0;
      end else begin
         redirect_count_q <= redirect_count_d;
         discard_count_q  <= discard_count_d;
         stall_cycles_q   <= stall_cycles_d;
      end
   end

   assign redirect_count = redirect_count_q;
   assign discard_count  = discard_count_q;
   assign stall_cycles   = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed test-plan steps followed
// by randomized traffic, all checked against a transaction-level reference model.
module tb_fetch_redirect_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, flush, stall, imem_ready;
   logic [1:0]  m4_1_cnt;
   logic [31:0] branch_target, jump_target, imem_rdata;
   logic        imem_req, if_id_valid, id_ex_flush, misalign_err;
   logic [31:0] imem_addr, if_id_pc, if_id_instr;
`ifdef FETCH_REDIRECT_STATS_EN
   logic [31:0] redirect_count, discard_count, stall_cycles;
`endif

   int tests = 0;
   int fails = 0;

   fetch_redirect_unit dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .m4_1_cnt      (m4_1_cnt),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_valid   (if_id_valid),
      .id_ex_flush   (id_ex_flush),
      .misalign_err  (misalign_err)
`ifdef FETCH_REDIRECT_STATS_EN
      ,
      .redirect_count(redirect_count),
      .discard_count (discard_count),
      .stall_cycles  (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the fetcher is either free, waiting on a stale fetch,
   // or holding one fetched instruction that the stalled decoder refused.
   logic [31:0] m_pc, m_redir, m_held_pc, m_held_ins, m_ifid_pc, m_ifid_ins;
   bit          m_holding, m_stale, m_ifid_val, m_mis;
   longint      m_nredir, m_ndisc, m_nstall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_redir = 32'h0; m_held_pc = 32'h0; m_held_ins = 32'h0;
      m_ifid_pc = 32'h0; m_ifid_ins = NOP; m_ifid_val = 0;
      m_holding = 0; m_stale = 0; m_mis = 0;
      m_nredir = 0; m_ndisc = 0; m_nstall = 0;
   endtask

   task automatic check_all();
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_holding});
      if (!m_holding) chk("imem_addr", imem_addr, m_pc);
      chk("id_ex_flush", {31'b0, id_ex_flush}, {31'b0, flush});
      chk("if_id_pc", if_id_pc, m_ifid_pc);
      chk("if_id_instr", if_id_instr, m_ifid_ins);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifid_val});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
`ifdef FETCH_REDIRECT_STATS_EN
      chk("redirect_count", redirect_count, sat(m_nredir));
      chk("discard_count", discard_count, sat(m_ndisc));
      chk("stall_cycles", stall_cycles, sat(m_nstall));
`endif
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model, clock.
   task automatic step(input bit r, input bit f, input logic [1:0] c, input logic [31:0] bt,
                       input logic [31:0] jt, input bit st, input bit rdy);
      logic [31:0] raw, tgt, data;
      @(negedge clk);
      data = $urandom;
      rst = r; flush = f; m4_1_cnt = c; branch_target = bt; jump_target = jt;
      stall = st; imem_ready = rdy; imem_rdata = data;
      #1;
      check_all();
      raw = (c == 2'b01) ? bt : (c == 2'b10) ? jt : m_pc + 32'd4;
      tgt = raw & 32'hFFFF_FFFC;
      if (r) begin
         model_reset();
      end else begin
         if (f) begin
            m_nredir++;
            if (raw[1:0] != 2'b00) m_mis = 1;
            m_ifid_pc = 32'h0; m_ifid_ins = NOP; m_ifid_val = 0;
         end
         if (st) m_nstall++;
         if (m_holding) begin
            if (f) begin
               m_holding = 0; m_pc = tgt;
            end else if (!st) begin
               m_ifid_pc = m_held_pc; m_ifid_ins = m_held_ins; m_ifid_val = 1; m_holding = 0;
            end
         end else if (m_stale) begin
            if (f) m_redir = tgt;
            if (rdy) begin
               m_ndisc++; m_pc = f ? tgt : m_redir; m_stale = 0;
            end
         end else if (rdy) begin
            if (f) begin
               m_ndisc++; m_pc = tgt;
            end else if (!st) begin
               m_ifid_pc = m_pc; m_ifid_ins = data; m_ifid_val = 1; m_pc = m_pc + 32'd4;
            end else begin
               m_held_pc = m_pc; m_held_ins = data; m_holding = 1; m_pc = m_pc + 32'd4;
            end
         end else if (f) begin
            m_redir = tgt; m_stale = 1;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] bt, jt;
      rst = 1'b1; flush = 1'b0; m4_1_cnt = 2'b00; branch_target = '0; jump_target = '0;
      stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // Sequential fetches: addresses 0,4,8,C.
      repeat (4) step(0, 0, 2'b00, 0, 0, 0, 1);
      // Taken branch with ready high.
      step(0, 1, 2'b01, 32'h40, 0, 0, 1);
      #1;
      chk("plan_branch_addr", imem_addr, 32'h40);
      chk("plan_branch_instr", if_id_instr, NOP);
      chk("plan_branch_valid", {31'b0, if_id_valid}, 32'h0);
      // Jump while the fetch is still outstanding.
      step(0, 1, 2'b10, 0, 32'h80, 0, 0);
      step(0, 0, 2'b00, 0, 0, 0, 0);
      #1;
      chk("plan_jump_addr_stable", imem_addr, 32'h40);
      step(0, 0, 2'b00, 0, 0, 0, 1);
      #1;
      chk("plan_jump_addr", imem_addr, 32'h80);
      // Stall as the fetch completes, then release.
      step(0, 0, 2'b00, 0, 0, 1, 1);
      step(0, 0, 2'b00, 0, 0, 1, 1);
      #1;
      chk("plan_hold_req", {31'b0, imem_req}, 32'h0);
      step(0, 0, 2'b00, 0, 0, 0, 0);
      #1;
      chk("plan_release_pc", if_id_pc, 32'h80);
      chk("plan_release_addr", imem_addr, 32'h84);
      // Newest redirect wins in the discard window.
      step(0, 1, 2'b01, 32'h100, 0, 0, 0);
      step(0, 1, 2'b01, 32'h200, 0, 0, 0);
      step(0, 0, 2'b00, 0, 0, 0, 1);
      #1;
      chk("plan_discard_addr", imem_addr, 32'h200);
      // Misaligned jump target is truncated and flagged.
      step(0, 1, 2'b10, 0, 32'h103, 0, 1);
      #1;
      chk("plan_misalign_addr", imem_addr, 32'h100);
      chk("plan_misalign_err", {31'b0, misalign_err}, 32'h1);
      // Sequential redirect (cnt=11) and PC wrap-around.
      step(0, 1, 2'b11, 0, 0, 0, 1);
      step(0, 1, 2'b10, 0, 32'hFFFF_FFFC, 0, 1);
      step(0, 0, 2'b00, 0, 0, 0, 1);
      #1;
      chk("plan_wrap_addr", imem_addr, 32'h0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         bt = $urandom; jt = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            bt[1:0] = 2'b00; jt[1:0] = 2'b00;
         end
         step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, 2'($urandom),
              bt, jt, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      step(1, 0, 2'b00, 0, 0, 0, 0);
      step(0, 0, 2'b00, 0, 0, 0, 0);
      #1;
      chk("final_reset_misalign", {31'b0, misalign_err}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
